// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: N-digit packed-BCD adder, one digit per clock LSD first, with start/busy/done and 7-seg outputs.
// Optional macro BCD_ADDER_SUB_EN adds a sub port (nine's-complement subtraction).
module bcd_serial_adder #(
    parameter int DIGITS     = 2,
    parameter bit START_HOLD = 1'b0
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    input  logic                  start,
`ifdef BCD_ADDER_SUB_EN
    input  logic                  sub,
`endif
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  invalid,
    output logic [7*DIGITS-1:0]   HEX
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, ADD, FIN} state_t;

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   a_q, a_d, b_q, b_d, wsum_q, wsum_d, sum_q, sum_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  c_q, c_d, winv_q, winv_d, cout_q, cout_d, inv_q, inv_d;
    logic                  done_q, done_d, start_q;
`ifdef BCD_ADDER_SUB_EN
    logic                  sub_q, sub_d;
`endif
    logic                  accept, carry;
    logic [3:0]            a_dig, b_raw, b_dig, dig;
    logic [4:0]            t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b0000110;
        endcase
    endfunction

    always_comb begin
        accept = (state_q == IDLE) && start && (START_HOLD || !start_q);
        a_dig  = a_q[4*idx_q +: 4];
        b_raw  = b_q[4*idx_q +: 4];
`ifdef BCD_ADDER_SUB_EN
        b_dig  = sub_q ? 4'd9 - b_raw : b_raw;
`else
        b_dig  = b_raw;
`endif
        t      = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0, c_q};
        carry  = t > 5'd9;
        dig    = carry ? 4'(t - 5'd10) : t[3:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        idx_d   = idx_q;
        wsum_d  = wsum_q;
        winv_d  = winv_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        inv_d   = inv_q;
        done_d  = 1'b0;
`ifdef BCD_ADDER_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            IDLE: if (accept) begin
                a_d     = A;
                b_d     = B;
`ifdef BCD_ADDER_SUB_EN
                sub_d   = sub;
                c_d     = sub | cin;
`else
                c_d     = cin;
`endif
                idx_d   = '0;
                winv_d  = 1'b0;
                state_d = ADD;
            end
            ADD: begin
                wsum_d[4*idx_q +: 4] = dig;
                c_d     = carry;
                winv_d  = winv_q | (a_dig > 4'd9) | (b_raw > 4'd9);
                idx_d   = idx_q + IW'(1);
                state_d = (idx_q == LAST) ? FIN : ADD;
            end
            FIN: begin
                sum_d   = winv_q ? '0 : wsum_q;
                cout_d  = !winv_q && c_q;
                inv_d   = winv_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
            wsum_q  <= '0;
            winv_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            inv_q   <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
`ifdef BCD_ADDER_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            wsum_q  <= wsum_d;
            winv_q  <= winv_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            inv_q   <= inv_d;
            done_q  <= done_d;
            start_q <= start;
`ifdef BCD_ADDER_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy    = state_q != IDLE;
    assign done    = done_q;
    assign sum     = sum_q;
    assign cout    = cout_q;
    assign invalid = inv_q;

    for (genvar i = 0; i < DIGITS; i++) begin : g_hex
        assign HEX[7*i +: 7] = seg7(sum_q[4*i +: 4]);
    end
endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: directed vectors for 2- and 4-digit instances, scoreboard-checked on done.
module tb_bcd_serial_adder;
    logic clk, rst;
    logic start2, cin2, busy2, done2, cout2, inv2;
    logic [7:0] A2, B2, sum2;
    logic [13:0] hex2;
    logic start4, cin4, busy4, done4, cout4, inv4;
    logic [15:0] A4, B4, sum4;
    logic [27:0] hex4;
`ifdef BCD_ADDER_SUB_EN
    logic sub2, sub4;
`endif

    typedef struct packed {logic [15:0] s; logic c; logic v;} exp_t;
    exp_t q2[$], q4[$];
    int n_chk = 0, n_fail = 0, done_cnt2 = 0, done_cnt4 = 0;

    bcd_serial_adder #(.DIGITS(2)) dut2 (
        .CLOCK_50(clk), .RESET(rst), .start(start2),
`ifdef BCD_ADDER_SUB_EN
        .sub(sub2),
`endif
        .A(A2), .B(B2), .cin(cin2), .busy(busy2), .done(done2),
        .sum(sum2), .cout(cout2), .invalid(inv2), .HEX(hex2));

    bcd_serial_adder #(.DIGITS(4)) dut4 (
        .CLOCK_50(clk), .RESET(rst), .start(start4),
`ifdef BCD_ADDER_SUB_EN
        .sub(sub4),
`endif
        .A(A4), .B(B4), .cin(cin4), .busy(busy4), .done(done4),
        .sum(sum4), .cout(cout4), .invalid(inv4), .HEX(hex4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return (d > 4'd9) ? 7'h06 : tbl[d];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) if (done2) begin : mon2
        exp_t e;
        done_cnt2++;
        if (q2.size() == 0) check("unexpected_done2", 1, 0);
        else begin
            e = q2.pop_front();
            check("sum2", 32'(sum2), 32'(e.s[7:0]));
            check("cout2", 32'(cout2), 32'(e.c));
            check("invalid2", 32'(inv2), 32'(e.v));
            check("hex2", 32'(hex2), 32'({seg(e.s[7:4]), seg(e.s[3:0])}));
            check("busy_at_done2", 32'(busy2), 0);
        end
    end

    always @(negedge clk) if (done4) begin : mon4
        exp_t e;
        done_cnt4++;
        if (q4.size() == 0) check("unexpected_done4", 1, 0);
        else begin
            e = q4.pop_front();
            check("sum4", 32'(sum4), 32'(e.s));
            check("cout4", 32'(cout4), 32'(e.c));
            check("invalid4", 32'(inv4), 32'(e.v));
            check("hex4", 32'(hex4), 32'({seg(e.s[15:12]), seg(e.s[11:8]), seg(e.s[7:4]), seg(e.s[3:0])}));
        end
    end

    task automatic op2(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic s,
                       input logic [7:0] es, input logic ec, input logic ev);
        int cyc, bc;
        @(negedge clk);
        A2 = a; B2 = b; cin2 = ci; start2 = 1'b1;
`ifdef BCD_ADDER_SUB_EN
        sub2 = s;
`endif
        q2.push_back('{s: 16'(es), c: ec, v: ev});
        @(negedge clk);
        start2 = 1'b0; A2 = 8'hFF; B2 = 8'hFF; cin2 = 1'b0;
        cyc = 1; bc = 0;
        while (!done2 && cyc < 30) begin
            if (busy2) bc++;
            @(negedge clk);
            cyc++;
        end
        check("latency2", cyc, 4);
        check("busy_cycles2", bc, 3);
        @(negedge clk);
        check("done_one_cycle2", 32'(done2), 0);
        if (s) begin end
    endtask

    initial begin : drv
        int cyc, d0;
        rst = 1'b1; start2 = 0; start4 = 0; A2 = 0; B2 = 0; cin2 = 0; A4 = 0; B4 = 0; cin4 = 0;
`ifdef BCD_ADDER_SUB_EN
        sub2 = 0; sub4 = 0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy2), 0);
        check("rst_done", 32'(done2), 0);
        check("rst_sum", 32'(sum2), 0);
        check("rst_cout_inv", 32'({cout2, inv2}), 0);
        check("rst_hex2", 32'(hex2), 32'({7'b1000000, 7'b1000000}));
        check("rst_hex4", 32'(hex4), 32'({4{7'b1000000}}));

        op2(8'h47, 8'h38, 0, 0, 8'h85, 0, 0);
        check("hex_85", 32'(hex2), 32'({7'b0000000, 7'b0010010}));
        op2(8'h99, 8'h99, 1, 0, 8'h99, 1, 0);
        op2(8'h00, 8'h00, 1, 0, 8'h01, 0, 0);
        op2(8'h3A, 8'h01, 0, 0, 8'h00, 0, 1);
        op2(8'h12, 8'h34, 0, 0, 8'h46, 0, 0);

        // second pulse during ADD must be ignored
        d0 = done_cnt2;
        @(negedge clk);
        A2 = 8'h21; B2 = 8'h13; cin2 = 0; start2 = 1;
        q2.push_back('{s: 16'h34, c: 1'b0, v: 1'b0});
        @(negedge clk); start2 = 0;
        @(negedge clk); A2 = 8'h55; B2 = 8'h44; start2 = 1;
        @(negedge clk); start2 = 0;
        repeat (8) @(negedge clk);
        check("busy_ignore_dones", done_cnt2 - d0, 1);

        // held start must not re-trigger
        d0 = done_cnt2;
        A2 = 8'h05; B2 = 8'h04; start2 = 1;
        q2.push_back('{s: 16'h09, c: 1'b0, v: 1'b0});
        repeat (12) @(negedge clk);
        start2 = 0;
        check("held_start_dones", done_cnt2 - d0, 1);

        // reset in the second ADD cycle aborts
        d0 = done_cnt2;
        @(negedge clk);
        A2 = 8'h11; B2 = 8'h22; start2 = 1;
        @(negedge clk); start2 = 0;
        @(negedge clk); rst = 1;
        #1;
        check("abort_busy", 32'(busy2), 0);
        check("abort_sum", 32'(sum2), 0);
        check("abort_hex", 32'(hex2), 32'({7'b1000000, 7'b1000000}));
        @(negedge clk); rst = 0;
        repeat (6) @(negedge clk);
        check("abort_no_done", done_cnt2 - d0, 0);
        op2(8'h28, 8'h19, 0, 0, 8'h47, 0, 0);

`ifdef BCD_ADDER_SUB_EN
        op2(8'h52, 8'h17, 0, 1, 8'h35, 1, 0);
        op2(8'h17, 8'h52, 0, 1, 8'h65, 0, 0);
`endif

        @(negedge clk);
        A4 = 16'h9999; B4 = 16'h0001; cin4 = 0; start4 = 1;
        q4.push_back('{s: 16'h0000, c: 1'b1, v: 1'b0});
        @(negedge clk); start4 = 0;
        cyc = 1;
        while (!done4 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("latency4", cyc, 6);

        repeat (3) @(negedge clk);
        check("q2_drained", q2.size(), 0);
        check("q4_drained", q4.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
Parametrised multi-digit BCD adder that adds two packed-BCD operands plus carry-in, one digit per clock, least-significant digit first. It uses a start/busy/done handshake, flags non-BCD input digits, and drives one active-low seven-segment display per result digit. It is the sequential, N-digit successor to the single-digit switch-driven BCD adder lab and sits between switch/operand logic and the HEX displays.

Parameters:
DIGITS, 2, number of BCD digits per operand (1..8)
START_HOLD, 0, 1 = start is level-sensitive (re-arms while held); 0 = start is taken as a rising-edge pulse

Ports:
CLOCK_50  input  1  system clock, all state on rising edge
RESET  input  1  asynchronous, active-high reset
start  input  1  begin an operation (sampled in IDLE only)
A  input  4*DIGITS  operand A, packed BCD, digit 0 = bits [3:0]
B  input  4*DIGITS  operand B, packed BCD
cin  input  1  carry into digit 0
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse, result valid
sum  output  4*DIGITS  packed BCD result, held until the next accepted start
cout  output  1  carry out of the most-significant digit
invalid  output  1  an operand digit was >9 in the last operation
HEX  output  7*DIGITS  active-low segments {g..a} per digit; digit i = bits [7i+6:7i]

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, sum=0, cout=0, invalid=0. HEX shows "0" (7'b1000000) on every digit.
- States: IDLE, ADD, FIN.
- IDLE: on accepted start, latch A, B and cin into internal registers, clear the digit index, clear the working invalid flag, and go to ADD. busy=1 from the next cycle.
- ADD: one digit per cycle at index i.
  - T = a_i + b_i + c (5-bit).
  - If T>9: digit = T-10, c=1; else digit = T, c=0.
  - Write the digit into the working sum register at index i.
  - If a_i>9 or b_i>9, set the working invalid flag.
  - After index DIGITS-1, go to FIN. Exactly DIGITS cycles are spent in ADD.
- FIN: one cycle.
  - Copy the working sum to sum and c to cout, unless the invalid flag is set; in that case sum=0, cout=0, invalid=1.
  - Pulse done=1, drop busy, and return to IDLE.
- Latency: start sampled at edge 0 gives done high during the cycle after edge DIGITS+1.
- start while busy is ignored; no queuing. With START_HOLD=0, a held start does not re-trigger; a new rising edge is required. With START_HOLD=1, start held high in IDLE re-triggers immediately after done.
- Operand inputs may change after acceptance; only the latched copies are used.
- sum, cout and invalid change only in FIN or on reset. The intermediate working sum is never visible on sum or HEX.
- HEX is combinational from the sum register.
  - Digits 0-9 use the standard active-low encoding.
  - An all-blank code (7'h7F) is never produced for valid sums.
  - Unreachable codes 10-15 display "E" (7'b0000110).
- RESET mid-operation aborts: no done pulse; outputs go to reset values.

Optional Feature:
Macro BCD_ADDER_SUB_EN.
- Defined: adds input port sub (1 bit), latched at start.
  - sub=1: computes A - B using the nine's complement of each B digit (9-b_i), with cin forced to 1.
  - cout=1 means A>=B with a non-negative result. cout=0 means the result is negative and sum holds the ten's complement.
  - The invalid check applies to the original b_i.
- Undefined: no sub port; addition only; logic is identical to the base behaviour.

Test Plan:
- DIGITS=2, A=0x47, B=0x38, cin=0, pulse start -> busy for 3 cycles, done once; sum=0x85, cout=0, invalid=0; HEX1=7'b0000000, HEX0=7'b0010010.
- DIGITS=2, A=0x99, B=0x99, cin=1 -> sum=0x99, cout=1. DIGITS=4, A=0x9999, B=0x0001, cin=0 -> sum=0x0000, cout=1, done 5 cycles after start.
- DIGITS=2, A=0x3A, B=0x01 -> done pulses; sum=0x00, cout=0, invalid=1. A following valid 0x12+0x34 -> sum=0x46, invalid=0.
- Second start pulse while busy, with different operands -> ignored; exactly one done, with results from the first operands.
- RESET asserted in the 2nd ADD cycle -> immediate return to IDLE, sum=0, no done; HEX all "0"; a new start then completes normally.
- With BCD_ADDER_SUB_EN, DIGITS=2: sub=1, A=0x52, B=0x17 -> sum=0x35, cout=1. A=0x17, B=0x52 -> sum=0x65, cout=0.
